// File: rtl/sn74_bus_arbiter_pkg.sv
// sn74_arb_pkg: shared types and constants for the 4-way bus arbiter.
// FSM state encoding, requester count and default burst counter width.
package sn74_arb_pkg;

  localparam int NREQ      = 4;
  localparam int CNT_W_DEF = 4;
  localparam int SEL_W     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    TURN  = 2'b10
  } state_e;

endpackage

// File: rtl/sn74_bus_arbiter_if.sv
// sn74_bus_arbiter_if: requester-side and arbiter-side bus bundle.
// master = requester/testbench side, slave = arbiter side.
interface sn74_bus_arbiter_if
  import sn74_arb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic [NREQ-1:0]  req;
  logic [CNT_W-1:0] blen;
  logic [NREQ-1:0]  gnt;
  logic [SEL_W-1:0] sel;
  logic             oe;
  logic             busy;
  logic             eob;

  modport master (
    output req, blen,
    input  gnt, sel, oe, busy, eob
  );

  modport slave (
    input  req, blen,
    output gnt, sel, oe, busy, eob
  );

endinterface

// File: rtl/sn74_bus_arbiter_burst_cnt.sv
// sn74_arb_burst_cnt: loadable burst down-counter that saturates at 0.
// Load has priority over decrement; zero_o flags the last beat.
module sn74_arb_burst_cnt
  import sn74_arb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             nclr,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] din_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: load, else decrement without wrapping below 0
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = din_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sn74_bus_arbiter.sv
// sn74_bus_arbiter: 4-way bus arbiter with burst hold and turnaround gap.
// Define SN74_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest).
module sn74_bus_arbiter
  import sn74_arb_pkg::*;
#(
  parameter int NREQ  = sn74_arb_pkg::NREQ,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic               clk,
  input logic               nclr,
  sn74_bus_arbiter_if.slave bus
);

  state_e           state_q;
  state_e           state_d;
  logic [SEL_W-1:0] own_q;
  logic [SEL_W-1:0] own_d;
  logic [SEL_W-1:0] win;
  logic             any_req;
  logic             take;
  logic             cnt_zero;
  logic             in_grant;
  logic [NREQ-1:0]  gnt_oh;

  assign any_req  = |bus.req;
  assign in_grant = (state_q == GRANT);
  assign take     = !in_grant && any_req;

`ifdef SN74_ARB_FIXED_PRIO_EN
  // lowest-index requester wins
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) win = SEL_W'(i);
    end
  end
`else
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] idx;

  // round-robin search from ptr+1; last owner ranks last
  always_comb begin
    win = ptr_q;
    idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = ptr_q + SEL_W'(i);
      if (bus.req[idx]) win = idx;
    end
  end

  // pointer follows every grant winner
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      ptr_q <= 2'd3;
    end else if (take) begin
      ptr_q <= win;
    end
  end
`endif

  sn74_arb_burst_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .nclr   (nclr),
    .load_i (take),
    .dec_i  (in_grant),
    .din_i  (bus.blen),
    .zero_o (cnt_zero)
  );

  // state and owner registers
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      state_q <= IDLE;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
    end
  end

  // next state: grant on any request, release on count end or drop
  always_comb begin
    state_d = state_q;
    own_d   = take ? win : own_q;
    unique case (state_q)
      IDLE:    state_d = any_req ? GRANT : IDLE;
      GRANT: begin
        if (cnt_zero || !bus.req[own_q]) state_d = TURN;
      end
      TURN:    state_d = any_req ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from state; sel holds owner outside GRANT
  always_comb begin
    gnt_oh = '0;
    if (in_grant) gnt_oh[own_q] = 1'b1;
    bus.gnt  = gnt_oh;
    bus.sel  = own_q;
    bus.oe   = !in_grant;
    bus.busy = in_grant;
    bus.eob  = (state_q == TURN);
  end

endmodule

// File: tb/tb_sn74_bus_arbiter.sv
// tb_sn74_bus_arbiter: directed scoreboard bench for sn74_bus_arbiter.
// Build with SN74_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_sn74_bus_arbiter;

  typedef struct {
    logic [8:0] v;
    string      tag;
  } exp_t;

  logic clk;
  logic nclr;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];
  logic       prev_drv;
  logic [1:0] prev_sel;

  sn74_bus_arbiter_if bus ();

  sn74_bus_arbiter dut (
    .clk  (clk),
    .nclr (nclr),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ev(logic [3:0] g, logic [1:0] s,
                                    logic o, logic e);
    return {g, s, o, ~o, e};
  endfunction

  function automatic logic [8:0] got();
    return {bus.gnt, bus.sel, bus.oe, bus.busy, bus.eob};
  endfunction

  task automatic chk(string tag, logic [8:0] a, logic [8:0] x);
    n_cmp++;
    if (a !== x) begin
      n_err++;
      $display("FAIL %s: got gnt/sel/oe/busy/eob=%b expected %b at %0t",
               tag, a, x, $time);
    end
  endtask

  task automatic step(logic [3:0] r, logic [3:0] b, logic [3:0] g,
                      logic [1:0] s, logic o, logic e, string tag);
    exp_t x;
    @(negedge clk);
    bus.req  = r;
    bus.blen = b;
    x.v   = ev(g, s, o, e);
    x.tag = tag;
    sb.push_back(x);
  endtask

  // monitor: pop expected response after each edge, plus bus invariants
  initial begin
    exp_t x;
    logic [3:0] oh;
    prev_drv = 1'b0;
    prev_sel = '0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        chk(x.tag, got(), x.v);
      end
      if (!bus.oe) begin
        oh = 4'b0001 << bus.sel;
        n_cmp++;
        if (bus.gnt !== oh) begin
          n_err++;
          $display("FAIL contention_onehot: gnt=%b sel=%0d need gnt=%b",
                   bus.gnt, bus.sel, oh);
        end
        if (prev_drv) begin
          n_cmp++;
          if (bus.sel !== prev_sel) begin
            n_err++;
            $display("FAIL sel_stable: sel=%0d need %0d",
                     bus.sel, prev_sel);
          end
        end
      end
      prev_drv = !bus.oe;
      prev_sel = bus.sel;
    end
  end

  initial begin
    logic [3:0] g;
    n_cmp    = 0;
    n_err    = 0;
    nclr     = 1'b0;
    bus.req  = '0;
    bus.blen = '0;
    #2;
    chk("reset_init", got(), ev(4'b0000, 2'd0, 1'b1, 1'b0));
    @(negedge clk);
    nclr = 1'b1;

    // burst of blen+1 = 4 cycles, non-owner and blen changes ignored
    step(4'b0010, 4'd3, 4'b0010, 2'd1, 1'b0, 1'b0, "burst_c1");
    step(4'b0011, 4'd0, 4'b0010, 2'd1, 1'b0, 1'b0, "burst_c2");
    step(4'b0011, 4'd9, 4'b0010, 2'd1, 1'b0, 1'b0, "burst_c3");
    step(4'b0011, 4'd0, 4'b0010, 2'd1, 1'b0, 1'b0, "burst_c4");
    step(4'b0000, 4'd0, 4'b0000, 2'd1, 1'b1, 1'b1, "burst_eob");
    step(4'b0000, 4'd0, 4'b0000, 2'd1, 1'b1, 1'b0, "burst_idle");
    step(4'b0000, 4'd0, 4'b0000, 2'd1, 1'b1, 1'b0, "idle_hold");

    // early release after 2 grant cycles of a 16-cycle burst
    step(4'b1000, 4'd15, 4'b1000, 2'd3, 1'b0, 1'b0, "early_c1");
    step(4'b1000, 4'd15, 4'b1000, 2'd3, 1'b0, 1'b0, "early_c2");
    step(4'b0000, 4'd15, 4'b0000, 2'd3, 1'b1, 1'b1, "early_eob");
    step(4'b0000, 4'd15, 4'b0000, 2'd3, 1'b1, 1'b0, "early_idle");
    step(4'b0000, 4'd15, 4'b0000, 2'd3, 1'b1, 1'b0, "early_noeob");

    // full 16-cycle burst ends on count, owner regrants after TURN
    for (int k = 0; k < 16; k++) begin
      step(4'b0100, 4'd15, 4'b0100, 2'd2, 1'b0, 1'b0, "full_hold");
    end
    step(4'b0100, 4'd0, 4'b0000, 2'd2, 1'b1, 1'b1, "full_eob");
    step(4'b0100, 4'd0, 4'b0100, 2'd2, 1'b0, 1'b0, "regrant");
    step(4'b0000, 4'd0, 4'b0000, 2'd2, 1'b1, 1'b1, "regrant_eob");
    step(4'b0000, 4'd0, 4'b0000, 2'd2, 1'b1, 1'b0, "regrant_idle");

    // asynchronous reset mid-burst
    step(4'b0100, 4'd5, 4'b0100, 2'd2, 1'b0, 1'b0, "pre_rst_c1");
    step(4'b0100, 4'd5, 4'b0100, 2'd2, 1'b0, 1'b0, "pre_rst_c2");
    @(posedge clk);
    #3;
    nclr = 1'b0;
    #1;
    chk("reset_async", got(), ev(4'b0000, 2'd0, 1'b1, 1'b0));
    @(posedge clk);
    #2;
    chk("reset_held", got(), ev(4'b0000, 2'd0, 1'b1, 1'b0));
    @(negedge clk);
    nclr     = 1'b1;
    bus.req  = '0;
    bus.blen = '0;

    // arbitration order with all requesting, blen = 0
`ifdef SN74_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) begin
      step(4'b1111, 4'd0, 4'b0001, 2'd0, 1'b0, 1'b0, "fp_gnt");
      step(4'b1111, 4'd0, 4'b0000, 2'd0, 1'b1, 1'b1, "fp_turn");
    end
`else
    for (int k = 0; k < 4; k++) begin
      g = 4'(1 << k);
      step(4'b1111, 4'd0, g, k[1:0], 1'b0, 1'b0, "rr_gnt");
      step(4'b1111, 4'd0, 4'b0000, k[1:0], 1'b1, 1'b1, "rr_turn");
    end
`endif
    step(4'b1111, 4'd0, 4'b0001, 2'd0, 1'b0, 1'b0, "arb_wrap");
    step(4'b0000, 4'd0, 4'b0000, 2'd0, 1'b1, 1'b1, "arb_exit");
    step(4'b0000, 4'd0, 4'b0000, 2'd0, 1'b1, 1'b0, "arb_idle");

    // random traffic: monitor checks contention invariants only
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      bus.req  = ($urandom_range(0, 3) == 0) ? 4'b0000
                                             : 4'($urandom_range(0, 15));
      bus.blen = 4'($urandom_range(0, 5));
    end
    @(negedge clk);
    bus.req = '0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d left, need 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
